// File: rtl/sr195_serializer_ctrl_if.sv
// Handshake and chain-control bundle between a word source and the SN74LS195 serializer controller.
interface sr195_serializer_ctrl_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         abort;
    logic         fill;
    logic         sh_ldn;
    logic         j;
    logic         kn;
    logic [W-1:0] par;
    logic         busy;
    logic         word_done;
    logic         underrun;

    modport master (
        output in_valid, in_data, abort, fill,
        input  in_ready, sh_ldn, j, kn, par, busy, word_done, underrun
    );

    modport slave (
        input  in_valid, in_data, abort, fill,
        output in_ready, sh_ldn, j, kn, par, busy, word_done, underrun
    );
endinterface

// File: rtl/sr195_serializer_ctrl.sv
// Sequences a chain of cascaded '195 shift registers so held words stream out of the last qd
// back-to-back, MSB first, reloading the chain in the LSB cycle of the previous word.
module sr195_serializer_ctrl #(
    parameter int NSTAGE = 2
) (
    input logic                    clk,
    input logic                    clrn,
    sr195_serializer_ctrl_if.slave bus
);
    localparam int unsigned W  = 4 * NSTAGE;
    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_W = CW'(W);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          load_now;
    logic          ready;
    logic          accept;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        accept      = bus.in_valid && ready;
        if (bus.abort) begin
            // Flush keeps hold contents so par stays stable through the abort.
            st_d        = IDLE;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end else begin
            if (load_now) begin
                st_d        = ACTIVE;
                cnt_d       = CW'(1);
                hold_full_d = 1'b0;
            end else if (st_q == ACTIVE) begin
                if (cnt_q < CNT_W) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end
            end
            if (accept) begin
                hold_d      = bus.in_data;
                hold_full_d = 1'b1;
            end
        end
    end

    always_comb begin
        load_now      = hold_full_q && (st_q == IDLE || cnt_q == CNT_W) && !bus.abort;
        ready         = !bus.abort && (!hold_full_q || load_now);
        bus.in_ready  = ready;
        bus.sh_ldn    = ~load_now;
        bus.j         = bus.fill;
        bus.kn        = bus.fill;
        bus.par       = hold_q;
        bus.busy      = (st_q == ACTIVE);
        bus.word_done = (st_q == ACTIVE) && (cnt_q == CNT_W);
        bus.underrun  = (st_q == ACTIVE) && (cnt_q == CNT_W) && !hold_full_q;
    end
endmodule

// File: tb/tb_sr195_serializer_ctrl.sv
// Bench for sr195_serializer_ctrl driving a behavioural 2-stage '195 chain: vector table,
// directed corner sequences, then random traffic against a word-queue reference model.
module tb_sr195_serializer_ctrl;
    localparam int NSTAGE = 2;
    localparam int W      = 4 * NSTAGE;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    sr195_serializer_ctrl_if #(.W(W)) bus ();

    sr195_serializer_ctrl #(.NSTAGE(NSTAGE)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Whole chain as one vector: bit W-1 is the last stage's qd, qa of stage 0 takes j.
    logic [W-1:0] chain_q;
    always @(posedge clk or negedge clrn) begin
        if (!clrn)            chain_q <= '0;
        else if (!bus.sh_ldn) chain_q <= bus.par;
        else                  chain_q <= {chain_q[W-2:0], bus.j};
    end
    wire qd = chain_q[W-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set(input logic v, input logic [W-1:0] d, input logic ab, input logic f);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.abort    = ab;
        bus.fill     = f;
        @(negedge clk);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         ab;
        logic         f;
        logic         rdy;
        logic         shl;
        logic         bsy;
        logic         dn;
        logic         ur;
        logic         cq;
        logic         qd;
        logic [W-1:0] par;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic v, logic [W-1:0] d, logic f, logic rdy, logic shl,
                                logic bsy, logic dn, logic ur, logic cq, logic q,
                                logic [W-1:0] par);
        vec_t r;
        r.v = v; r.d = d; r.ab = 1'b0; r.f = f; r.rdy = rdy; r.shl = shl; r.bsy = bsy;
        r.dn = dn; r.ur = ur; r.cq = cq; r.qd = q; r.par = par;
        tbl.push_back(r);
    endfunction

    // Reference model: current word with the bit index on qd, and a one-deep queue of held words.
    int           m_bidx;
    logic [W-1:0] m_cur;
    logic [W-1:0] m_last;
    logic [W-1:0] m_pend[$];

    initial begin
        logic [W-1:0] w;
        logic v, ab, f;
        logic e_busy, e_done, e_ur, e_load, e_rdy;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.abort    = 1'b0;
        bus.fill     = 1'b1;

        // Single word 0xA5 after two idle cycles.
        add(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'hA5, 1, 1, 1, 0, 0, 0, 0, 0, 8'h00);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8'hA5);
        w = 8'hA5;
        for (int k = 1; k <= W; k++)
            add(0, 0, 1, 1, 1, 1, k == W, k == W, 1, w[W-k], 8'hA5);
        add(0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 8'hA5);
        add(0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 8'hA5);
        // Streaming 0xFF, 0x00, 0x3C with in_valid held until the last word is taken.
        add(1, 8'hFF, 1, 1, 1, 0, 0, 0, 0, 0, 8'hA5);
        add(1, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 8'hFF);
        for (int k = 1; k <= W; k++)
            add(1, 8'h3C, 1, k == W, k != W, 1, k == W, 0, 1, 1, 8'h00);
        for (int k = 1; k <= W; k++)
            add(0, 0, 1, k == W, k != W, 1, k == W, 0, 1, 0, 8'h3C);
        w = 8'h3C;
        for (int k = 1; k <= W; k++)
            add(0, 0, 1, 1, 1, 1, k == W, k == W, 1, w[W-k], 8'h3C);
        add(0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 8'h3C);

        // Reset held low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst par", bus.par, 0);
            chk("rst sh_ldn", bus.sh_ldn, 1);
            chk("rst in_ready", bus.in_ready, 1);
            chk("rst busy", bus.busy, 0);
            chk("rst word_done", bus.word_done, 0);
            chk("rst underrun", bus.underrun, 0);
            chk("rst j", bus.j, 1);
            chk("rst kn", bus.kn, 1);
        end
        nxt;
        clrn = 1'b1;

        foreach (tbl[i]) begin
            set(tbl[i].v, tbl[i].d, tbl[i].ab, tbl[i].f);
            chk($sformatf("row%0d in_ready", i), bus.in_ready, tbl[i].rdy);
            chk($sformatf("row%0d sh_ldn", i), bus.sh_ldn, tbl[i].shl);
            chk($sformatf("row%0d busy", i), bus.busy, tbl[i].bsy);
            chk($sformatf("row%0d word_done", i), bus.word_done, tbl[i].dn);
            chk($sformatf("row%0d underrun", i), bus.underrun, tbl[i].ur);
            chk($sformatf("row%0d j", i), bus.j, tbl[i].f);
            chk($sformatf("row%0d kn", i), bus.kn, tbl[i].f);
            chk($sformatf("row%0d par", i), bus.par, tbl[i].par);
            if (tbl[i].cq) chk($sformatf("row%0d qd", i), qd, tbl[i].qd);
            nxt;
        end

        // Backpressure: second word taken while the first shifts, third only at word_done.
        set(1, 8'h11, 0, 1); chk("bp rdy1", bus.in_ready, 1); nxt;
        set(0, 0, 0, 1);     chk("bp load", bus.sh_ldn, 0); nxt;
        set(1, 8'h22, 0, 1); chk("bp rdy2", bus.in_ready, 1); chk("bp busy", bus.busy, 1); nxt;
        set(1, 8'h33, 0, 1);
        for (int c = 2; c < W; c++) begin
            chk($sformatf("bp rdy low cnt%0d", c), bus.in_ready, 0);
            chk($sformatf("bp par cnt%0d", c), bus.par, 8'h22);
            nxt;
            set(1, 8'h33, 0, 1);
        end
        chk("bp done", bus.word_done, 1);
        chk("bp rdy at done", bus.in_ready, 1);
        chk("bp no underrun", bus.underrun, 0);
        chk("bp reload", bus.sh_ldn, 0);
        nxt;
        set(0, 0, 0, 1);
        chk("bp par third", bus.par, 8'h33);
        chk("bp busy2", bus.busy, 1);
        chk("bp qd msb of 22", qd, 0);
        nxt;

        // Abort at cnt=3 with 0x33 pending.
        set(0, 0, 0, 1); nxt;
        set(1, 8'h77, 1, 1);
        chk("ab rdy", bus.in_ready, 0);
        chk("ab sh_ldn", bus.sh_ldn, 1);
        nxt;
        set(0, 0, 0, 1);
        chk("ab busy", bus.busy, 0);
        chk("ab rdy after", bus.in_ready, 1);
        chk("ab par kept", bus.par, 8'h33);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("ab no load %0d", c), bus.sh_ldn, 1);
            chk($sformatf("ab idle %0d", c), bus.busy, 0);
            nxt;
            set(0, 0, 0, 1);
        end

        // Reset mid-stream at cnt=5 with 0x55 held.
        set(1, 8'h44, 0, 1); nxt;
        set(0, 0, 0, 1);     nxt;
        set(1, 8'h55, 0, 1); nxt;
        for (int c = 2; c < 5; c++) begin set(0, 0, 0, 1); nxt; end
        set(0, 0, 0, 1);
        chk("rs busy before", bus.busy, 1);
        #2 clrn = 1'b0;
        #1;
        chk("rs busy", bus.busy, 0);
        chk("rs sh_ldn", bus.sh_ldn, 1);
        chk("rs rdy", bus.in_ready, 1);
        chk("rs par", bus.par, 0);
        chk("rs done", bus.word_done, 0);
        @(negedge clk);
        clrn = 1'b1;
        nxt;
        for (int c = 0; c < 12; c++) begin
            set(0, 0, 0, 1);
            chk($sformatf("rs no emit %0d", c), bus.busy, 0);
            chk($sformatf("rs no load %0d", c), bus.sh_ldn, 1);
            nxt;
        end

        // Random traffic against the reference model.
        clrn = 1'b0;
        nxt;
        clrn = 1'b1;
        m_bidx = -1;
        m_cur  = '0;
        m_last = '0;
        m_pend.delete();
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 99) < 60);
            ab = ($urandom_range(0, 15) == 0);
            f  = 1'($urandom_range(0, 1));
            w  = W'($urandom);
            set(v, w, ab, f);
            e_busy = (m_bidx >= 0);
            e_done = (m_bidx == 0);
            e_ur   = e_done && (m_pend.size() == 0);
            e_load = (m_pend.size() > 0) && (m_bidx <= 0) && !ab;
            e_rdy  = !ab && ((m_pend.size() == 0) || e_load);
            chk("rnd in_ready", bus.in_ready, e_rdy);
            chk("rnd sh_ldn", bus.sh_ldn, !e_load);
            chk("rnd busy", bus.busy, e_busy);
            chk("rnd word_done", bus.word_done, e_done);
            chk("rnd underrun", bus.underrun, e_ur);
            chk("rnd j", bus.j, f);
            chk("rnd par", bus.par, m_last);
            if (e_busy) chk("rnd qd", qd, m_cur[m_bidx]);
            if (ab) begin
                m_bidx = -1;
                m_pend.delete();
            end else begin
                if (e_load) begin
                    m_cur  = m_pend.pop_front();
                    m_bidx = W - 1;
                end else if (m_bidx >= 0) begin
                    m_bidx--;
                end
                if (v && e_rdy) begin
                    m_pend.push_back(w);
                    m_last = w;
                end
            end
            nxt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not reach its summary, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/sr195_serializer_ctrl.md
# sr195_serializer_ctrl

Sequencing controller for a chain of NSTAGE cascaded SN74LS195 4-bit shift registers used as a parallel-in/serial-out serializer (video/cassette bit streams). It accepts words through a valid/ready handshake and holds one word in a holding register. It drives the chain's shared sh_ldn, j and kn inputs and its parallel load bus so that words stream out of the last stage's qd back-to-back, MSB first, with no gap cycles. The chain itself stays outside this block; its stages are clocked by the same clk and cleared by the same clrn.

## Interface
- NSTAGE, default 2: number of cascaded 4-bit stages. W = 4*NSTAGE is the word width. NSTAGE ≥ 1.
- clk  in  1  clock, rising edge; also clocks the external chain.
- clrn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  word offered.
- in_data  in  W  word to serialize.
- in_ready  out  1  holding register can accept this cycle.
- abort  in  1  synchronous flush; has priority over all other inputs.
- fill  in  1  bit shifted into the chain whenever no word is being loaded.
- sh_ldn  out  1  to every stage: 0 = parallel load, 1 = shift.
- j, kn  out  1 each  to stage 0 only. Both equal fill.
- par  out  W  parallel bus. par[4s+3:4s] drives {d,c,b,a} of stage s. Stage s qd feeds j and kn of stage s+1.
- busy  out  1  a word is being emitted on the last stage's qd.
- word_done  out  1  high in the cycle the LSB of the current word is on the last stage's qd.
- underrun  out  1  high in a word_done cycle when no next word is held.

## Operation
- State: st ∈ {IDLE, ACTIVE}, cnt (width clog2(W+1)), hold register, hold_full flag.
- par always presents the hold register.
- load_now = hold_full && (st==IDLE || cnt==W) && !abort.
- sh_ldn = ~load_now. j = kn = fill, always (combinational).
- in_ready = !abort && (!hold_full || load_now).
- Handshake: a word is accepted on a rising edge with in_valid && in_ready. On acceptance, hold takes in_data and hold_full is set.
- At a load_now edge:
  - hold_full clears, unless a word is accepted on the same edge; in that case it stays set and hold takes the new word.
  - st becomes ACTIVE and cnt becomes 1.
- ACTIVE with cnt < W: cnt increments.
- ACTIVE with cnt==W and no load_now: st becomes IDLE and cnt becomes 0.
- busy = (st==ACTIVE).
- word_done = (st==ACTIVE && cnt==W).
- underrun = word_done && !hold_full.
- While ACTIVE with cnt=k, the chain's last qd carries bit W-k of the word loaded at the last load_now edge.
- In IDLE the chain keeps shifting fill toward qd, because a 195 has no hold mode.
- abort edge: st←IDLE, cnt←0, hold_full←0. The hold contents are retained and par is unchanged. During an abort cycle sh_ldn=1 and in_ready=0.
- A word held in IDLE loads in the very next cycle; IDLE does not wait for anything.

## Timing
- Reset values (also the values while clrn is low): st=IDLE, cnt=0, hold=0, hold_full=0. Resulting outputs:
  - par=0, sh_ldn=1, in_ready=1, busy=0, word_done=0, underrun=0.
  - j=kn=fill.
- Reset asserted mid-word: all state clears immediately. The external chain is also cleared by the same clrn.
- Latency from acceptance edge (chain idle) to MSB on qd: 2 edges.
  - Edge 1 accepts the word.
  - The next cycle has sh_ldn=0.
  - Edge 2 loads the chain; the MSB is on qd in the following cycle.
- Load period while streaming: exactly W cycles. sh_ldn is low for exactly one cycle per word, coinciding with the word_done cycle of the previous word.
- A second word must be accepted no later than the previous word's word_done edge to avoid a gap. in_ready is high in the word_done cycle even when hold_full=1, so back-to-back refill works with in_valid held high.
- Simultaneous abort and in_valid: the word is not accepted.

## Test plan
- Reset and idle: clrn low, then high with fill=1 and no in_valid. Required: sh_ldn=1, in_ready=1, busy=0, j=kn=1, par=0 on every cycle.
- Single word: NSTAGE=2, send 0xA5 to the bench-instantiated 195 chain. Required:
  - sh_ldn=0 for one cycle, 1 cycle after acceptance.
  - qd sequence 1,0,1,0,0,1,0,1 over cycles 1..8 after the load.
  - word_done in cycle 8, underrun=1.
  - Return to IDLE; qd then shows fill.
- Streaming: words 0xFF, 0x00 and 0x3C with in_valid held high. Required: 24 contiguous qd bits with no gap, sh_ldn low every 8th cycle, no underrun until after the last word.
- Backpressure: offer a second word while the first shifts, then a third. Required:
  - The second word is accepted and in_ready drops to 0.
  - The third word is accepted only in the word_done cycle; par switches to the third word after that edge.
- Abort mid-word: assert abort at cnt=3. Required: next cycle st=IDLE, busy=0, in_ready=1, sh_ldn=1, the pending held word is discarded, and no load follows.
- Reset mid-stream: drop clrn at cnt=5 with a word held. Required: outputs return immediately to reset values, and the held word is not emitted after release.
